// File: rtl/golden_nonce_arbiter.sv
// -----------------------------------------------------------------------------
// golden_nonce_arbiter
//
// Purpose:
//   Collects golden-nonce hits from NUM_CORES parallel miner cores and
//   serialises them into a first-word-fallthrough result FIFO. The UART
//   result transmitter drains the FIFO over a valid/ready handshake.
//   - Each core has a one-deep pending register.
//   - A round-robin arbiter moves one pending hit per cycle into the FIFO.
//   - job_reset flushes stale results whenever new work is loaded.
//
// Ports:
//   hash_clk     in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   job_reset    in   synchronous flush (new_work); overrides hits and pops
//   core_found   in   [NUM_CORES] single-cycle hit pulse per core
//   core_nonce   in   [NUM_CORES*32] core i nonce on bits [32i+31:32i]
//   out_valid    out  FIFO head valid
//   out_ready    in   consumer accepts the head
//   out_nonce    out  [32] head nonce (holds its last value while empty)
//   out_core     out  [CORE_W] head core index (holds its last value while empty)
//   fifo_level   out  current FIFO occupancy
//   drop_count   out  [8] saturating count of lost hits
// -----------------------------------------------------------------------------
module golden_nonce_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_W     = $clog2(NUM_CORES)
) (
    input  logic                          hash_clk,
    input  logic                          reset_n,
    input  logic                          job_reset,
    input  logic [NUM_CORES-1:0]          core_found,
    input  logic [NUM_CORES*32-1:0]       core_nonce,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_nonce,
    output logic [CORE_W-1:0]             out_core,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = CORE_W + 32;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [31:0]          pend_nonce_q [NUM_CORES];
    logic [31:0]          pend_nonce_d [NUM_CORES];
    logic [CORE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]           drop_q, drop_d;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [31:0]          head_nonce_q, head_nonce_d;
    logic [CORE_W-1:0]    head_core_q, head_core_d;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    logic              push_ok;
    logic              grant_vld;
    logic [CORE_W-1:0] grant_idx;
    int                srch_idx;

    // Push eligibility uses the level before this cycle's pop, so a full
    // FIFO that is being drained still defers the next push by one cycle.
    assign push_ok = (level_q < LVL_W'(FIFO_DEPTH));

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        srch_idx  = 0;
        if (push_ok) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                srch_idx = int'(rr_ptr_q) + k;
                if (srch_idx >= NUM_CORES) begin
                    srch_idx = srch_idx - NUM_CORES;
                end
                if (!grant_vld && pend_q[srch_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = CORE_W'(srch_idx);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (job_reset) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            if (grant_idx == CORE_W'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + CORE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending stage and drop accounting
    // ------------------------------------------------------------------
    logic [8:0] drop_sum;
    logic [8:0] drop_total;
    logic       granted_i;

    always_comb begin
        pend_d       = pend_q;
        pend_nonce_d = pend_nonce_q;
        drop_sum     = '0;
        granted_i    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            granted_i = grant_vld && (grant_idx == CORE_W'(i));
            if (core_found[i]) begin
                // A hit landing on the cycle its slot is granted refills the
                // slot rather than being lost.
                if (!pend_q[i] || granted_i) begin
                    pend_d[i]       = 1'b1;
                    pend_nonce_d[i] = core_nonce[32*i +: 32];
                end else begin
                    drop_sum = drop_sum + 9'd1;
                end
            end else if (granted_i) begin
                pend_d[i] = 1'b0;
            end
        end
        if (job_reset) begin
            pend_d = '0;
        end
    end

    always_comb begin
        drop_total = {1'b0, drop_q} + drop_sum;
        drop_d     = drop_q;
        if (!job_reset) begin
            drop_d = (drop_total > 9'd255) ? 8'hFF : drop_total[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic [LVL_W-1:0]   level_after_pop;

    assign out_valid  = (level_q != '0);
    assign pop        = out_valid && out_ready;
    assign push       = grant_vld;
    assign push_entry = {grant_idx, pend_nonce_q[grant_idx]};

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        head_nonce_d    = head_nonce_q;
        head_core_d     = head_core_q;
        level_after_pop = level_q - LVL_W'(pop);
        if (job_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_after_pop + LVL_W'(push);

            // The head register presents the entry at rd_ptr_d. If the FIFO
            // would be empty after the pop, the new head is the entry being
            // pushed right now, which is not yet in the array.
            if (push && (level_after_pop == '0)) begin
                {head_core_d, head_nonce_d} = push_entry;
            end else if (level_d != '0) begin
                {head_core_d, head_nonce_d} = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push && !job_reset) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= '0;
            rr_ptr_q     <= '0;
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            head_nonce_q <= '0;
            head_core_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_nonce_q[i] <= '0;
            end
        end else begin
            pend_q       <= pend_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            head_nonce_q <= head_nonce_d;
            head_core_q  <= head_core_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_nonce_q[i] <= pend_nonce_d[i];
            end
        end
    end

    assign out_nonce  = head_nonce_q;
    assign out_core   = head_core_q;
    assign fifo_level = level_q;
    assign drop_count = drop_q;

endmodule

// File: doc/golden_nonce_arbiter.md
# golden_nonce_arbiter

Collects golden-nonce hits from `NUM_CORES` parallel miner cores in the `hash_clk` domain and serialises them into a first-word-fallthrough result FIFO. The FIFO is drained by the UART result transmitter over a valid/ready handshake. Each core gets a one-deep pending register, a round-robin arbiter grants one pending hit per cycle into the FIFO, and a job reset flushes all stale results when new work arrives.

## Interface
- `NUM_CORES`, 4: number of miner cores; 2..16.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, 2..16.
- `CORE_W`, `$clog2(NUM_CORES)`: width of the core index.
- `hash_clk` input 1: single clock; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `job_reset` input 1: synchronous flush, asserted when a new job is loaded (`new_work`).
- `core_found` input NUM_CORES: per-core single-cycle hit pulse.
- `core_nonce` input NUM_CORES*32: per-core nonce; core i occupies bits [32i+31:32i] and is valid when `core_found[i]` is high.
- `out_valid` output 1: the FIFO head is valid.
- `out_ready` input 1: the consumer accepts the head.
- `out_nonce` output 32: head nonce.
- `out_core` output CORE_W: head core index.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `drop_count` output 8: saturating count of lost hits.

## Operation
- Pending stage, per core i: `pend[i]` flag plus 32-bit `pend_nonce[i]`.
  - `core_found[i]` with `pend[i]`=0: capture the nonce and set `pend[i]`.
  - `core_found[i]` with `pend[i]`=1 and not granted this cycle: the new hit is dropped, `drop_count`+1, and the stored nonce is kept.
  - `core_found[i]` in the same cycle that `pend[i]` is granted: the new nonce is captured and `pend[i]` stays 1. This is not a drop.
- Arbiter is combinational over `pend` and is enabled only when `push_ok` = (`fifo_level` < FIFO_DEPTH).
  - Grants the first set `pend[j]` searching from `rr_ptr` upward, modulo NUM_CORES.
  - On grant: push {j, `pend_nonce[j]`}, clear `pend[j]` unless re-captured the same cycle, and set `rr_ptr` to (j+1) mod NUM_CORES.
  - `rr_ptr` does not move when there is no grant.
- FIFO: circular buffer with read/write pointers and a level counter.
  - Pop = `out_valid` & `out_ready`.
  - A push is gated only by `push_ok`, using the level before this cycle's pop. When full, a pop does not enable a same-cycle push; the push waits one cycle.
  - Pointers wrap modulo FIFO_DEPTH. The level is updated by +1, −1 or 0 when push and pop coincide.
- `out_nonce`/`out_core` show the head entry while `out_valid`=1. They hold their last value when the FIFO is empty.
- `drop_count` saturates at 255. Multiple simultaneous drops in one cycle add their count, clamped to 255.
- `job_reset`=1 clears all `pend` flags, empties the FIFO (pointers and level to 0, `out_valid` to 0) and resets `rr_ptr` to 0.
  - It does not clear `drop_count`.
  - It has priority over every `core_found` and pop in the same cycle; those hits are discarded and not counted as drops.

## Timing
- Reset values: `out_valid`=0, `out_nonce`=0, `out_core`=0, `fifo_level`=0, `drop_count`=0; `pend`=0, `rr_ptr`=0.
- Latency from hit to output, with an empty FIFO and no contention:
  - `core_found` at cycle t sets `pend` at t+1.
  - The grant and push happen at the t+1 edge.
  - `out_valid`=1 with the data at t+2.
- Throughput: one push per cycle and one pop per cycle.
- Handshake: once `out_valid` is high, it and its data stay stable until a pop or `job_reset`.
- `reset_n` asserted mid-operation clears everything asynchronously. Outputs are at reset values in the same cycle, and the first push is possible one cycle after deassertion.

## Test plan
- Single hit:
  - Stimulus: core 2 pulses with nonce 0xDEADBEEF at t; `out_ready`=1.
  - Response: `out_valid`=1 at t+2 with `out_nonce`=0xDEADBEEF and `out_core`=2; popped at t+2, with `fifo_level` returning to 0 after that pop edge; `drop_count`=0.
- Simultaneous hits:
  - Stimulus: all 4 cores pulse at t with nonces 0x10..0x13; `out_ready`=1.
  - Response: outputs are cores 0,1,2,3 with nonces 0x10..0x13 on consecutive cycles t+2..t+5.
- Round-robin fairness:
  - Stimulus: after the previous case, cores 0 and 3 pulse together.
  - Response: core 0 is granted first, because `rr_ptr`=0 after the grant to core 3, then core 3.
- Backpressure:
  - Stimulus: `out_ready`=0; 6 hits spread over cores 0..3 in separate cycles.
  - Response: `fifo_level`=4, two hits wait in `pend`; raising `out_ready` drains all 6 in grant order with `drop_count`=0.
- Drop:
  - Stimulus: `out_ready`=0 and FIFO full; core 1 pulses 0xA then 0xB.
  - Response: `drop_count`=1; when drained, core 1 delivers 0xA.
- Flush:
  - Stimulus: 3 entries queued and core 0 pending; assert `job_reset` in the same cycle as a core 2 hit.
  - Response: next cycle `out_valid`=0, `fifo_level`=0, no pending hits, `drop_count` unchanged; `reset_n` low mid-burst gives all outputs 0 immediately.
